wb_sram_ctrl: RTL and testbench
===============================

Name: wb_sram_ctrl

Overview:
Wishbone B4 pipelined slave that bridges the uart2wb debug host bus to an external asynchronous SRAM, such as the 16-bit board SRAM.
- Accepts one single-beat access at a time.
- Runs the SRAM read or write strobe sequence with programmable wait states.
- Returns a one-cycle ack.
- Sits directly downstream of uart2wb on the debug bus.

Parameters:
- AW, 16, Wishbone address width (word address).
- DW, 16, data width; must be a multiple of 8.
- SRAM_AW, 16, SRAM address width; must be <= AW.
- RD_WAIT, 1, extra SRAM read cycles beyond one (0..15).
- WR_WAIT, 1, extra SRAM write-pulse cycles beyond one (0..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  1 = write
- wb_adr_i  in  AW  word address
- wb_dat_i  in  DW  write data
- wb_sel_i  in  DW/8  byte enables
- wb_dat_o  out  DW  read data
- wb_ack_o  out  1  access complete
- wb_stall_o  out  1  cannot accept a request
- sram_addr  out  SRAM_AW  SRAM address
- sram_dq_i  in  DW  SRAM data in
- sram_dq_o  out  DW  SRAM data out
- sram_dq_oe  out  1  pad output enable
- sram_ce_n  out  1  chip enable
- sram_oe_n  out  1  output enable
- sram_we_n  out  1  write enable
- sram_be_n  out  DW/8  byte enables, active-low

Behaviour:
Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.

Reset values:
- wb_ack_o=0, wb_stall_o=0, wb_dat_o=0.
- sram_ce_n/oe_n/we_n=1, sram_be_n all 1, sram_dq_oe=0, sram_addr=0, sram_dq_o=0.
- Reset asserted mid-access returns the block to IDLE immediately (asynchronously). All SRAM strobes go inactive at once; no ack is issued.

Request acceptance:
- A request is accepted on a rising edge where wb_cyc_i & wb_stb_i & !wb_stall_o.
- On accept, latch: sram_addr <= wb_adr_i[SRAM_AW-1:0] (upper bits ignored), we, sram_be_n <= ~wb_sel_i, sram_dq_o <= wb_dat_i.
- wb_stall_o = (state != IDLE). At most one access is outstanding.

State machine (IDLE, ACCESS, ACK):
- IDLE -> ACCESS on accept. Load wait_cnt = we ? WR_WAIT : RD_WAIT.
- ACCESS: wait_cnt decrements each cycle. When wait_cnt==0, go to ACK.
- ACK: lasts one cycle, then -> IDLE.

SRAM outputs:
- All SRAM outputs are flops, updated on the same edge as the state.
- ACCESS: sram_ce_n=0.
  - Read: sram_oe_n=0.
  - Write: sram_we_n=0 and sram_dq_oe=1.
- ACK:
  - ce_n, oe_n and we_n return to 1.
  - On a write, sram_dq_oe stays 1 through ACK to provide data hold after we_n rises; it drops when returning to IDLE.
  - On a read, sram_dq_oe is never asserted.

Read data:
- wb_dat_o <= sram_dq_i on the edge leaving ACCESS, when oe has been low for RD_WAIT+1 cycles.
- wb_dat_o then holds until the next read.

Ack:
- wb_ack_o=1 during ACK only if wb_cyc_i=1 in that cycle.
- Latency from the accept edge to the ack edge is WAIT+2 cycles.
- Throughput is one access per WAIT+3 cycles.

Abort and fixed-value cases:
- wb_cyc_i dropping during ACCESS does not abort the SRAM sequence, so there are no torn writes; the ack is suppressed.
- WAIT=0: ACCESS lasts exactly one cycle.
- wb_sel_i=0 on a write: the strobe sequence still runs, with all sram_be_n=1 (no bytes written).

Decomposition:
- Package uart_debug_pkg: state_t enum {IDLE, ACCESS, ACK}, and WAIT_W=4 (wait counter width).
- No sub-module. This is a single flat module, with the wait counter and strobe flops inline.

Test Plan:
1. Write adr=16'h0012, dat=16'hBEEF, sel=2'b11, WR_WAIT=1 -> sram_we_n low for exactly 2 cycles with sram_addr=16'h0012; sram_dq_oe high for 3 cycles; ack one cycle at accept+3; stall high for 3 cycles.
2. Read adr=16'h0012, SRAM model returning 16'hBEEF, RD_WAIT=1 -> sram_oe_n low for 2 cycles; ack at accept+3 with wb_dat_o=16'hBEEF; sram_dq_oe never high.
3. Write sel=2'b10, dat=16'hAA55 to a location holding 16'h1234 -> sram_be_n=2'b01; subsequent read returns 16'hAA34.
4. Back-to-back: stb held with two requests (write 16'h0001 to adr 5, then read adr 5) -> second is accepted only on the edge after ACK (stall observed); read returns 16'h0001; no lost or duplicated acks.
5. Drop wb_cyc_i in the 2nd ACCESS cycle of a write, with RD_WAIT=WR_WAIT=3 -> sram_we_n stays low for all 4 cycles; wb_ack_o stays 0; returns to IDLE with stall=0.
6. Assert rst_n=0 asynchronously mid-ACCESS of a read -> sram_ce_n/oe_n go to 1 and stall to 0 without waiting for a clock edge; no ack after release; the next read completes normally.

Source files
------------

// File: rtl/uart_debug_pkg.sv
// Shared types for the uart2wb debug bus slaves.
//   state_t : wb_sram_ctrl access sequencer states
//   WAIT_W  : width of the SRAM wait-state counter (0..15 extra cycles)
package uart_debug_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    localparam int WAIT_W = 4;

endpackage

// File: rtl/wb_sram_ctrl.sv
// Wishbone B4 pipelined slave bridging the debug bus to an asynchronous SRAM.
// One single-beat access is in flight at a time. Each access is:
//   accept edge -> ACCESS (WAIT+1 cycles, strobes low) -> ACK (1 cycle) -> IDLE.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   wb_cyc_i..wb_sel_i   Wishbone request (word address, byte selects)
//   wb_dat_o, wb_ack_o   read data (held until next read), one-cycle ack
//   wb_stall_o           high whenever an access is in progress
//   sram_*               registered SRAM address/data/strobes; sram_dq_oe
//                        drives the bidirectional data pads at the top level
module wb_sram_ctrl
    import uart_debug_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int SRAM_AW = 16,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_we_i,
    input  logic [AW-1:0]        wb_adr_i,
    input  logic [DW-1:0]        wb_dat_i,
    input  logic [DW/8-1:0]      wb_sel_i,
    output logic [DW-1:0]        wb_dat_o,
    output logic                 wb_ack_o,
    output logic                 wb_stall_o,
    output logic [SRAM_AW-1:0]   sram_addr,
    input  logic [DW-1:0]        sram_dq_i,
    output logic [DW-1:0]        sram_dq_o,
    output logic                 sram_dq_oe,
    output logic                 sram_ce_n,
    output logic                 sram_oe_n,
    output logic                 sram_we_n,
    output logic [DW/8-1:0]      sram_be_n
);

    state_t              state_q;
    logic [WAIT_W-1:0]   wait_cnt_q;
    logic                we_q;
    logic [DW-1:0]       rdata_q;
    logic [SRAM_AW-1:0]  addr_q;
    logic [DW-1:0]       dq_o_q;
    logic                dq_oe_q;
    logic                ce_n_q;
    logic                oe_n_q;
    logic                we_n_q;
    logic [DW/8-1:0]     be_n_q;
    logic                accept;

    assign wb_stall_o = (state_q != IDLE);
    assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;

    // The SRAM sequence always runs to completion once started; dropping
    // cyc only masks the ack, so a write is never torn.
    assign wb_ack_o   = (state_q == ACK) & wb_cyc_i;

    assign wb_dat_o   = rdata_q;
    assign sram_addr  = addr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_be_n  = be_n_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            we_q       <= 1'b0;
            rdata_q    <= '0;
            addr_q     <= '0;
            dq_o_q     <= '0;
            dq_oe_q    <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            be_n_q     <= '1;
        end else begin
            case (state_q)
                IDLE: begin
                    dq_oe_q <= 1'b0;
                    if (accept) begin
                        state_q    <= ACCESS;
                        wait_cnt_q <= wb_we_i ? WAIT_W'(WR_WAIT) : WAIT_W'(RD_WAIT);
                        we_q       <= wb_we_i;
                        addr_q     <= wb_adr_i[SRAM_AW-1:0];
                        dq_o_q     <= wb_dat_i;
                        be_n_q     <= ~wb_sel_i;
                        ce_n_q     <= 1'b0;
                        oe_n_q     <= wb_we_i;
                        we_n_q     <= ~wb_we_i;
                        dq_oe_q    <= wb_we_i;
                    end
                end
                ACCESS: begin
                    if (wait_cnt_q == '0) begin
                        state_q <= ACK;
                        ce_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        we_n_q  <= 1'b1;
                        // oe has been low for RD_WAIT+1 cycles here
                        if (!we_q)
                            rdata_q <= sram_dq_i;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - WAIT_W'(1);
                    end
                end
                ACK: begin
                    // write data is held through ACK after we_n rises
                    state_q <= IDLE;
                    dq_oe_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_sram_ctrl.sv
module tb_wb_sram_ctrl;

    localparam int A_RW = 1, A_WW = 1;   // DUT A: default wait states, full address
    localparam int B_RW = 0, B_WW = 3;   // DUT B: zero-wait read, long write, 8-bit SRAM address

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        cyc_a = 0, cyc_b = 0, stb = 0, we = 0;
    logic [15:0] adr = 0, dat = 0;
    logic [1:0]  sel = 0;

    logic [15:0] do_a, ad_a, dqi_a, dqo_a;
    logic        ack_a, st_a, dqoe_a, cen_a, oen_a, wen_a;
    logic [1:0]  ben_a;
    logic [15:0] do_b, dqi_b, dqo_b;
    logic [7:0]  ad_b;
    logic        ack_b, st_b, dqoe_b, cen_b, oen_b, wen_b;
    logic [1:0]  ben_b;

    wb_sram_ctrl #(.AW(16), .DW(16), .SRAM_AW(16), .RD_WAIT(A_RW), .WR_WAIT(A_WW)) dut_a (
        .clk(clk), .rst_n(rst_n), .wb_cyc_i(cyc_a), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel), .wb_dat_o(do_a), .wb_ack_o(ack_a),
        .wb_stall_o(st_a), .sram_addr(ad_a), .sram_dq_i(dqi_a), .sram_dq_o(dqo_a),
        .sram_dq_oe(dqoe_a), .sram_ce_n(cen_a), .sram_oe_n(oen_a), .sram_we_n(wen_a),
        .sram_be_n(ben_a));

    wb_sram_ctrl #(.AW(16), .DW(16), .SRAM_AW(8), .RD_WAIT(B_RW), .WR_WAIT(B_WW)) dut_b (
        .clk(clk), .rst_n(rst_n), .wb_cyc_i(cyc_b), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel), .wb_dat_o(do_b), .wb_ack_o(ack_b),
        .wb_stall_o(st_b), .sram_addr(ad_b), .sram_dq_i(dqi_b), .sram_dq_o(dqo_b),
        .sram_dq_oe(dqoe_b), .sram_ce_n(cen_b), .sram_oe_n(oen_b), .sram_we_n(wen_b),
        .sram_be_n(ben_b));

    // Asynchronous SRAM models: byte-masked write while we_n low, read while oe_n low.
    logic [15:0] mem_a [0:65535];
    logic [15:0] mem_b [0:255];
    logic [15:0] ref_a [0:65535];
    logic [15:0] ref_b [0:255];

    assign dqi_a = (!cen_a && !oen_a) ? mem_a[ad_a] : 16'hDEAD;
    assign dqi_b = (!cen_b && !oen_b) ? mem_b[ad_b] : 16'hDEAD;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!cen_a && !wen_a && !ben_a[i]) mem_a[ad_a][i*8 +: 8] <= dqo_a[i*8 +: 8];
            if (!cen_b && !wen_b && !ben_b[i]) mem_b[ad_b][i*8 +: 8] <= dqo_b[i*8 +: 8];
        end
    end

    int total = 0;
    int bad = 0;

    // Reference memory: a write merges the selected bytes, nothing else.
    task automatic ref_wr(input bit b, input logic [15:0] a, input logic [15:0] d, input logic [1:0] s);
        for (int i = 0; i < 2; i++)
            if (s[i]) begin
                if (b) ref_b[a[7:0]][i*8 +: 8] = d[i*8 +: 8];
                else   ref_a[a][i*8 +: 8] = d[i*8 +: 8];
            end
    endtask

    function automatic logic [15:0] ref_rd(input bit b, input logic [15:0] a);
        return b ? ref_b[a[7:0]] : ref_a[a];
    endfunction

    // One access with cyc held to the end; counts strobe widths (samples at negedge).
    task automatic wb_xfer(input bit b, input bit w, input logic [15:0] a, input logic [15:0] d,
                           input logic [1:0] s, output logic [15:0] rd, output int lat,
                           output int wel, output int oel, output int dqh, output int stl,
                           output int acks, output bit ok);
        logic [15:0] exp_ad;
        rd = '0; lat = -1; wel = 0; oel = 0; dqh = 0; stl = 0; acks = 0; ok = 1'b1;
        exp_ad = b ? {8'h00, a[7:0]} : a;
        @(negedge clk);
        if (b) cyc_b = 1'b1; else cyc_a = 1'b1;
        stb = 1'b1; we = w; adr = a; dat = d; sel = s;
        for (int k = 0; k < 50 && (b ? st_b : st_a); k++) @(negedge clk);
        @(posedge clk);
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (n == 1) stb = 1'b0;
            if (b ? ack_b : ack_a) begin
                acks++;
                if (lat < 0) begin lat = n; rd = b ? do_b : do_a; end
            end
            if ((b ? cen_b : cen_a) !== ((b ? wen_b : wen_a) & (b ? oen_b : oen_a))) ok = 1'b0;
            if (!(b ? wen_b : wen_a)) begin
                wel++;
                if ((b ? {8'h00, ad_b} : ad_a) !== exp_ad || (b ? ben_b : ben_a) !== ~s ||
                    (b ? dqo_b : dqo_a) !== d) ok = 1'b0;
            end
            if (!(b ? oen_b : oen_a)) begin
                oel++;
                if ((b ? {8'h00, ad_b} : ad_a) !== exp_ad) ok = 1'b0;
            end
            if (b ? dqoe_b : dqoe_a) dqh++;
            if (b ? st_b : st_a) stl++;
        end
        cyc_a = 1'b0; cyc_b = 1'b0;
        if (w) ref_wr(b, a, d, s);
    endtask

    logic [15:0] rd;
    int lat, wel, oel, dqh, stl, acks;
    bit ok;

    task automatic test_reset();
        #12;
        total++;
        if ({ack_a, st_a, do_a, cen_a, oen_a, wen_a, ben_a, dqoe_a, ad_a, dqo_a} !==
            {1'b0, 1'b0, 16'h0, 3'b111, 2'b11, 1'b0, 16'h0, 16'h0})
            begin bad++; $display("FAIL reset_a got ack=%b stall=%b dat=%h ce/oe/we=%b%b%b be=%b oe=%b addr=%h dq=%h",
                ack_a, st_a, do_a, cen_a, oen_a, wen_a, ben_a, dqoe_a, ad_a, dqo_a); end
        total++;
        if ({ack_b, st_b, cen_b, oen_b, wen_b, ben_b, dqoe_b, ad_b} !== {2'b00, 3'b111, 2'b11, 1'b0, 8'h0})
            begin bad++; $display("FAIL reset_b got %b exp 0011111000000000", {ack_b, st_b, cen_b, oen_b, wen_b, ben_b, dqoe_b, ad_b}); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        wb_xfer(0, 1, 16'h0012, 16'hBEEF, 2'b11, rd, lat, wel, oel, dqh, stl, acks, ok);
        total++;
        if ({lat, wel, oel, dqh, stl, acks} !== {A_WW + 2, A_WW + 1, 0, A_WW + 2, A_WW + 2, 1})
            begin bad++; $display("FAIL write_timing got lat=%0d we=%0d oe=%0d dqoe=%0d stall=%0d acks=%0d exp %0d %0d 0 %0d %0d 1",
                lat, wel, oel, dqh, stl, acks, A_WW + 2, A_WW + 1, A_WW + 2, A_WW + 2); end
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL write_signals got addr/be/dq mismatch exp ok"); end
        total++;
        if (mem_a[16'h0012] !== 16'hBEEF) begin bad++; $display("FAIL write_mem got %h exp beef", mem_a[16'h0012]); end
    endtask

    task automatic test_read();
        wb_xfer(0, 0, 16'h0012, 16'h0, 2'b11, rd, lat, wel, oel, dqh, stl, acks, ok);
        total++;
        if (rd !== 16'hBEEF) begin bad++; $display("FAIL read_data got %h exp beef", rd); end
        total++;
        if ({lat, wel, oel, dqh, acks, 31'd0, ok} !== {A_RW + 2, 0, A_RW + 1, 0, 1, 32'd1})
            begin bad++; $display("FAIL read_timing got lat=%0d we=%0d oe=%0d dqoe=%0d acks=%0d ok=%b exp %0d 0 %0d 0 1 1",
                lat, wel, oel, dqh, acks, ok, A_RW + 2, A_RW + 1); end
    endtask

    task automatic test_byte_en();
        wb_xfer(0, 1, 16'h0033, 16'h1234, 2'b11, rd, lat, wel, oel, dqh, stl, acks, ok);
        wb_xfer(0, 1, 16'h0033, 16'hAA55, 2'b10, rd, lat, wel, oel, dqh, stl, acks, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL byte_en_be got mismatch exp be_n=01"); end
        wb_xfer(0, 0, 16'h0033, 16'h0, 2'b11, rd, lat, wel, oel, dqh, stl, acks, ok);
        total++;
        if (rd !== 16'hAA34) begin bad++; $display("FAIL byte_en_read got %h exp aa34", rd); end
        // no byte selected: sequence still runs, memory untouched
        wb_xfer(0, 1, 16'h0033, 16'h0000, 2'b00, rd, lat, wel, oel, dqh, stl, acks, ok);
        total++;
        if ({wel, acks, 31'd0, ok} !== {A_WW + 1, 1, 32'd1} || mem_a[16'h0033] !== 16'hAA34)
            begin bad++; $display("FAIL sel_zero got we=%0d acks=%0d ok=%b mem=%h exp %0d 1 1 aa34",
                wel, acks, ok, mem_a[16'h0033], A_WW + 1); end
    endtask

    task automatic test_back_to_back();
        int a1, a2, nacks, nst;
        bit racc;
        logic [15:0] rdat;
        a1 = -1; a2 = -1; nacks = 0; nst = 0; racc = 0; rdat = '0;
        @(negedge clk);
        cyc_a = 1; stb = 1; we = 1; adr = 16'd5; dat = 16'h0001; sel = 2'b11;
        @(posedge clk);
        ref_wr(0, 16'd5, 16'h0001, 2'b11);
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 1) begin we = 0; dat = 16'h0; end
            if (ack_a) begin
                nacks++;
                if (a1 < 0) a1 = n; else begin a2 = n; rdat = do_a; end
            end
            if (st_a) nst++;
            if (racc) stb = 0;
            else if (!st_a) racc = 1;
        end
        cyc_a = 0; stb = 0;
        total++;
        if ({nacks, a1, a2, nst} !== {2, A_WW + 2, A_WW + 3 + A_RW + 2, A_WW + A_RW + 4})
            begin bad++; $display("FAIL b2b_acks got n=%0d first=%0d second=%0d stall=%0d exp 2 %0d %0d %0d",
                nacks, a1, a2, nst, A_WW + 2, A_WW + A_RW + 5, A_WW + A_RW + 4); end
        total++;
        if (rdat !== ref_rd(0, 16'd5)) begin bad++; $display("FAIL b2b_data got %h exp %h", rdat, ref_rd(0, 16'd5)); end
    endtask

    task automatic test_abort();
        int nwe, nacks;
        nwe = 0; nacks = 0;
        @(negedge clk);
        cyc_b = 1; stb = 1; we = 1; adr = 16'h0107; dat = 16'h5A5A; sel = 2'b11;
        @(posedge clk);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) stb = 0;
            if (n == 2) cyc_b = 0;
            if (!wen_b) nwe++;
            if (ack_b) nacks++;
        end
        ref_wr(1, 16'h0107, 16'h5A5A, 2'b11);
        total++;
        if ({nwe, nacks, 31'd0, st_b} !== {B_WW + 1, 0, 32'd0})
            begin bad++; $display("FAIL abort got we_low=%0d acks=%0d stall=%b exp %0d 0 0", nwe, nacks, st_b, B_WW + 1); end
        // zero-wait read, upper address bits ignored by the narrow SRAM port
        wb_xfer(1, 0, 16'hFF07, 16'h0, 2'b11, rd, lat, wel, oel, dqh, stl, acks, ok);
        total++;
        if ({rd, lat, oel, acks, 31'd0, ok} !== {16'h5A5A, B_RW + 2, B_RW + 1, 1, 32'd1})
            begin bad++; $display("FAIL wait0_read got dat=%h lat=%0d oe=%0d acks=%0d ok=%b exp 5a5a %0d %0d 1 1",
                rd, lat, oel, acks, ok, B_RW + 2, B_RW + 1); end
    endtask

    task automatic test_reset_mid();
        int nacks;
        nacks = 0;
        @(negedge clk);
        cyc_a = 1; stb = 1; we = 0; adr = 16'h0012; sel = 2'b11;
        @(posedge clk);
        #2 stb = 0;
        total++;
        if ({cen_a, oen_a, st_a} !== 3'b001) begin bad++; $display("FAIL rst_pre got %b exp 001", {cen_a, oen_a, st_a}); end
        #1 rst_n = 0;
        #1;
        total++;
        if ({cen_a, oen_a, wen_a, st_a, ack_a} !== 5'b11100)
            begin bad++; $display("FAIL rst_async got %b exp 11100", {cen_a, oen_a, wen_a, st_a, ack_a}); end
        @(negedge clk); rst_n = 1;
        for (int n = 0; n < 6; n++) begin @(negedge clk); if (ack_a) nacks++; end
        cyc_a = 0;
        total++;
        if (nacks !== 0) begin bad++; $display("FAIL rst_no_ack got %0d exp 0", nacks); end
        wb_xfer(0, 0, 16'h0012, 16'h0, 2'b11, rd, lat, wel, oel, dqh, stl, acks, ok);
        total++;
        if ({rd, lat, acks} !== {ref_rd(0, 16'h0012), A_RW + 2, 1})
            begin bad++; $display("FAIL rst_next_read got dat=%h lat=%0d acks=%0d exp %h %0d 1", rd, lat, acks, ref_rd(0, 16'h0012), A_RW + 2); end
    endtask

    task automatic test_random();
        bit w;
        logic [15:0] a, d;
        logic [1:0] s;
        for (int i = 0; i < 30; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 16'(32 + $urandom_range(0, 7));
            d = 16'($urandom);
            s = 2'($urandom_range(0, 3));
            wb_xfer(0, w, a, d, s, rd, lat, wel, oel, dqh, stl, acks, ok);
            total++;
            if (w) begin
                if ({acks, lat, 31'd0, ok} !== {1, A_WW + 2, 32'd1})
                    begin bad++; $display("FAIL rnd_write[%0d] got acks=%0d lat=%0d ok=%b exp 1 %0d 1", i, acks, lat, ok, A_WW + 2); end
            end else begin
                if ({rd, acks} !== {ref_rd(0, a), 1})
                    begin bad++; $display("FAIL rnd_read[%0d] adr=%h got %h acks=%0d exp %h 1", i, a, rd, acks, ref_rd(0, a)); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin mem_a[i] = '0; ref_a[i] = '0; end
        for (int i = 0; i < 256; i++) begin mem_b[i] = '0; ref_b[i] = '0; end
        test_reset();
        test_write();
        test_read();
        test_byte_en();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
